mem_stage_sram_ctrl: RTL
========================

// Module: mem_stage_sram_ctrl
// PURPOSE
//   Memory-stage consumer of the EX/MEM pipeline register outputs.
//   Turns one 32-bit load/store request into two half-word accesses on the off-chip 16-bit SRAM, each held for a fixed number of wait cycles.
//   While an access is in flight it drops ready, which freezes the IF..EX/MEM pipeline registers.
//   Load data goes to the MEM/WB register on the cycle ready returns.
// PARAMETERS
//   WAIT_CYCLES  5     cycles each SRAM half-word phase is held (>=1)
//   BASE_ADDR    1024  data-memory base byte address, subtracted before translation
//   SRAM_AW      18    SRAM address width (half-word granular)
// PORTS
//   clk          in   1        single clock, all state updates on rising edge
//   rst          in   1        synchronous, active-high reset
//   mem_r_en     in   1        load request (from EX/MEM MEM_R_EN)
//   mem_w_en     in   1        store request (from EX/MEM MEM_W_EN)
//   address      in   32       byte address (from EX/MEM ALU result)
//   wr_data      in   32       store data (from EX/MEM Rm value)
//   rd_data      out  32       load result to MEM/WB
//   ready        out  1        1 = no access pending / access completes this cycle
//   sram_addr    out  SRAM_AW  SRAM half-word address
//   sram_dq_out  out  16       SRAM write data
//   sram_dq_in   in   16       SRAM read data
//   sram_dq_oe   out  1        1 = drive sram_dq_out onto the bus
//   sram_we_n    out  1        SRAM write enable, active low
// BEHAVIOUR
//   Reset:
//     state=IDLE, rd_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0.
//   Address translation:
//     - word = (address - BASE_ADDR)[SRAM_AW:2], a 32-bit unsigned subtract, truncated; it wraps and no range check is made.
//     - address[1:0] is ignored.
//     - LO phase addr = {word,1'b0}; HI phase addr = {word,1'b1}.
//     - LO carries bits [15:0]; HI carries bits [31:16].
//   FSM states: IDLE, LO, HI, DONE.
//     - IDLE: if mem_w_en|mem_r_en -> LO, latch op/addr/data, counter=0; else stay.
//     - LO: counter increments each cycle; at counter==WAIT_CYCLES-1 -> HI, counter=0.
//     - HI: same counting; at counter==WAIT_CYCLES-1 -> DONE.
//     - DONE: -> IDLE unconditionally. Inputs are ignored, so a request is never reissued.
//   ready (combinational):
//     ready = (IDLE & ~mem_r_en & ~mem_w_en) | DONE.
//   Latency: request seen in IDLE at cycle 0.
//     - ready=0 for cycles 0..2*WAIT_CYCLES.
//     - ready=1 in cycle 2*WAIT_CYCLES+1 (DONE).
//     - The pipeline advances on that edge, so the next request is seen in IDLE one cycle later.
//   Store:
//     - In LO/HI, sram_we_n=0, sram_dq_oe=1, sram_dq_out = the latched half.
//     - sram_addr is stable for the whole phase.
//     - rd_data is unchanged.
//   Load:
//     - In LO/HI, sram_we_n=1, sram_dq_oe=0.
//     - sram_dq_in is sampled on the last cycle of each phase into rd_data[15:0] / rd_data[31:16].
//     - rd_data holds its value until the next load completes.
//   Simultaneous mem_r_en & mem_w_en: treated as a store.
//   Outside LO/HI: sram_we_n=1, sram_dq_oe=0, sram_addr holds its last value.
//   Request inputs are sampled only in IDLE. Changes during LO/HI/DONE have no effect (ops are latched).
//   rst asserted in any state:
//     - Next edge gives reset values and state IDLE.
//     - A partial store may have written only LO; this is accepted.
// TESTING
//   1. Store address=1028, wr_data=32'hDEADBEEF, WAIT_CYCLES=5 ->
//      sram_addr=2 with dq_out=16'hBEEF for cycles 1-5, sram_addr=3 with 16'hDEAD for cycles 6-10;
//      we_n=0 in both phases; ready=0 in cycles 0-10 and ready=1 in cycle 11.
//   2. Load address=1028 with SRAM model returning the stored words ->
//      rd_data=32'hDEADBEEF when ready rises; we_n stays 1 throughout.
//   3. Back-to-back store then load, with requests held until ready ->
//      exactly one DONE per op; second op enters LO in cycle 13; no duplicate SRAM write.
//   4. rd and wr both high, address=1024, wr_data=32'h00010002 ->
//      SRAM words 0/1 = 2/1; rd_data is unchanged.
//   5. rst pulsed at cycle 3 of the LO phase of a store ->
//      next cycle state IDLE, we_n=1, oe=0, rd_data=0, and ready follows the request inputs.
//   6. No requests for 20 cycles after reset ->
//      ready=1 constantly, we_n=1, oe=0, sram_addr=0.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - memory-stage controller splitting 32-bit loads/stores into two waited 16-bit SRAM accesses
module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WW = SRAM_AW - 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} stateType;

    stateType      state, stateNext;
    logic [CW-1:0] counter;
    logic          opWrite;
    logic [WW-1:0] wordReg;
    logic [15:0]   dataHi;
    logic [WW-1:0] word;
    logic          request;
    logic          phaseEnd;

    // Word index of the 32-bit access; wraps silently outside the data window.
    assign word     = WW'((address - BASE_ADDR) >> 2);
    assign request  = mem_r_en | mem_w_en;
    assign phaseEnd = (counter == CW'(WAIT_CYCLES - 1));

    always_comb begin
        stateNext = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~request;
                if (request) stateNext = LO;
            end
            LO:   if (phaseEnd) stateNext = HI;
            HI:   if (phaseEnd) stateNext = DONE;
            DONE: begin
                ready     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            opWrite     <= 1'b0;
            wordReg     <= '0;
            dataHi      <= '0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (request) begin
                        // A simultaneous read+write is handled as a store.
                        opWrite     <= mem_w_en;
                        wordReg     <= word;
                        dataHi      <= wr_data[31:16];
                        counter     <= '0;
                        sram_addr   <= {word, 1'b0};
                        sram_dq_out <= wr_data[15:0];
                        sram_dq_oe  <= mem_w_en;
                        sram_we_n   <= ~mem_w_en;
                    end
                end
                LO: begin
                    if (phaseEnd) begin
                        counter     <= '0;
                        if (!opWrite) rd_data[15:0] <= sram_dq_in;
                        sram_addr   <= {wordReg, 1'b1};
                        sram_dq_out <= dataHi;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                HI: begin
                    if (phaseEnd) begin
                        counter    <= '0;
                        if (!opWrite) rd_data[31:16] <= sram_dq_in;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
